// File: rtl/tick_scheduler.sv
// tick_scheduler: shared timebase. A prescaler makes a base clock-enable
// tick. Four channels divide that tick into programmable-period pulses and
// square waves. A valid/ready port reprograms one channel period at a time,
// and each update lands on a base-tick boundary so that no runt period occurs.
module tick_scheduler #(
    parameter int CLK_HZ   = 50000000,
    parameter int BASE_HZ  = 1000,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_chan,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                cfg_done,
    output logic                base_tick,
    output logic [3:0]          ch_tick,
    output logic [3:0]          ch_wave,
    output logic [3:0]          ch_active
);

    localparam int PRESCALE = CLK_HZ / BASE_HZ;
    localparam int CNT_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] PRE_EARLY = CNT_W'(PRESCALE - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [CNT_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic                base_tick_q, base_tick_d;

    state_t              state_q;
    logic                cfg_ready_q;
    logic                cfg_done_q;
    logic [1:0]          hold_chan_q;
    logic [PERIOD_W-1:0] hold_period_q;
    logic                apply;

    logic [PERIOD_W-1:0] period_q [4];
    logic [PERIOD_W-1:0] period_d [4];
    logic [PERIOD_W-1:0] cnt_q    [4];
    logic [PERIOD_W-1:0] cnt_d    [4];
    logic [3:0]          tick_q, tick_d;
    logic [3:0]          wave_q, wave_d;
    logic [3:0]          active_q, active_d;

    // Prescaler next state; base_tick is registered one count early so it
    // lines up with the cycle where the count equals PRESCALE-1.
    always_comb begin
        pre_cnt_d   = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + CNT_W'(1);
        base_tick_d = (pre_cnt_q == PRE_EARLY);
    end

    // Prescaler registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            pre_cnt_q   <= '0;
            base_tick_q <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            base_tick_q <= base_tick_d;
        end
    end

    // Configuration FSM: capture in IDLE, wait for a base tick to apply,
    // then a single DONE cycle. A tick coincident with capture is skipped
    // because the update only becomes eligible once in WAIT.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b1;
            cfg_done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cfg_done_q <= 1'b0;
                    if (cfg_valid && cfg_ready_q) begin
                        state_q       <= S_WAIT;
                        cfg_ready_q   <= 1'b0;
                        hold_chan_q   <= cfg_chan;
                        hold_period_q <= cfg_period;
                    end
                end
                S_WAIT: begin
                    if (base_tick_q) begin
                        state_q    <= S_DONE;
                        cfg_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    cfg_ready_q <= 1'b1;
                    cfg_done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cfg_ready_q <= 1'b1;
                    cfg_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign apply = (state_q == S_WAIT) && base_tick_q;

    // Channel next state: an applied update restarts the channel and swallows
    // this base tick; a zero period parks the channel; otherwise count ticks.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            tick_d[i]   = 1'b0;
            wave_d[i]   = wave_q[i];
            if (apply && (hold_chan_q == 2'(i))) begin
                period_d[i] = hold_period_q;
                cnt_d[i]    = '0;
                wave_d[i]   = 1'b0;
            end else if (period_q[i] == '0) begin
                cnt_d[i]  = '0;
                wave_d[i] = 1'b0;
            end else if (base_tick_q) begin
                if (cnt_q[i] == period_q[i] - PERIOD_W'(1)) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    wave_d[i] = ~wave_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                end
            end
            active_d[i] = (period_d[i] != '0);
        end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            tick_q   <= '0;
            wave_q   <= '0;
            active_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            tick_q   <= tick_d;
            wave_q   <= wave_d;
            active_q <= active_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_done  = cfg_done_q;
    assign base_tick = base_tick_q;
    assign ch_tick   = tick_q;
    assign ch_wave   = wave_q;
    assign ch_active = active_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler with PRESCALE=5 (CLK_HZ=20, BASE_HZ=4).
// The reference model works in absolute cycle numbers: base ticks fall on
// t%5==4, an update accepted at cycle a applies at the next base tick after
// a, and a channel applied at cycle A with period P ticks at A+1+5*P*k, k>=1.
module tb_tick_scheduler;

    logic        clk = 1'b0;
    logic        Reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [15:0] cfg_period;
    logic        cfg_done;
    logic        base_tick;
    logic [3:0]  ch_tick;
    logic [3:0]  ch_wave;
    logic [3:0]  ch_active;

    tick_scheduler #(
        .CLK_HZ(20),
        .BASE_HZ(4),
        .PERIOD_W(16)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan),
        .cfg_period(cfg_period),
        .cfg_done(cfg_done),
        .base_tick(base_tick),
        .ch_tick(ch_tick),
        .ch_wave(ch_wave),
        .ch_active(ch_active)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int rel;
    int per [4];
    int aat [4];
    bit pend;
    int acc_c, apply_c, pch, pper;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d got=%0h expected=%0h", tag, rel, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            per[i] = 0;
            aat[i] = 0;
        end
        pend = 1'b0;
        rel  = 0;
    endtask

    // Check the current cycle against the model, drive this cycle's inputs,
    // then advance to the next cycle.
    task automatic step(input bit v, input logic [1:0] ch, input logic [15:0] p);
        bit       e_ready, e_done, e_base;
        logic [3:0] e_tick, e_wave, e_act;
        int d;
        if (pend && rel == apply_c + 1) begin
            per[pch] = pper;
            aat[pch] = apply_c;
        end
        if (pend && rel > apply_c + 1) pend = 1'b0;
        e_base  = (rel % 5 == 4);
        e_ready = !(pend && rel > acc_c && rel <= apply_c + 1);
        e_done  = pend && (rel == apply_c + 1);
        for (int i = 0; i < 4; i++) begin
            e_act[i]  = (per[i] != 0);
            e_tick[i] = 1'b0;
            e_wave[i] = 1'b0;
            if (per[i] != 0) begin
                d = rel - aat[i] - 1;
                if (d > 0) begin
                    e_tick[i] = (d % (5 * per[i]) == 0);
                    e_wave[i] = ((d / (5 * per[i])) % 2 == 1);
                end
            end
        end
        chk("base_tick", 32'(base_tick), 32'(e_base));
        chk("cfg_ready", 32'(cfg_ready), 32'(e_ready));
        chk("cfg_done",  32'(cfg_done),  32'(e_done));
        chk("ch_tick",   32'(ch_tick),   32'(e_tick));
        chk("ch_wave",   32'(ch_wave),   32'(e_wave));
        chk("ch_active", 32'(ch_active), 32'(e_act));
        cfg_valid  = v;
        cfg_chan   = ch;
        cfg_period = p;
        if (v && e_ready) begin
            pend    = 1'b1;
            acc_c   = rel;
            pch     = int'(ch);
            pper    = int'(p);
            apply_c = (rel % 5 == 4) ? rel + 5 : rel + (4 - rel % 5);
        end
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic run_to(input int n);
        while (rel < n)
            step(1'b0, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
    endtask

    // Hold Reset for n cycles while presenting a request that must be ignored.
    task automatic do_reset(input int n);
        Reset      = 1'b1;
        cfg_valid  = 1'b1;
        cfg_chan   = 2'd2;
        cfg_period = 16'd1;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_ready",  32'(cfg_ready), 32'd1);
            chk("rst_done",   32'(cfg_done),  32'd0);
            chk("rst_base",   32'(base_tick), 32'd0);
            chk("rst_tick",   32'(ch_tick),   32'd0);
            chk("rst_wave",   32'(ch_wave),   32'd0);
            chk("rst_active", 32'(ch_active), 32'd0);
        end
        Reset     = 1'b0;
        cfg_valid = 1'b0;
        model_clear();
    endtask

    initial begin
        Reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_chan   = 2'd0;
        cfg_period = 16'd0;
        model_clear();

        // 1: free-running base tick, nothing configured
        do_reset(3);
        run_to(4);
        chk("t1_base4", 32'(base_tick), 32'd1);
        run_to(19);
        chk("t1_base19", 32'(base_tick), 32'd1);
        run_to(20);

        // 2: ch0 period 3 requested at cycle 1
        do_reset(2);
        run_to(1);
        step(1'b1, 2'd0, 16'd3);
        chk("t2_ready2", 32'(cfg_ready), 32'd0);
        run_to(5);
        chk("t2_done5", 32'(cfg_done), 32'd1);
        chk("t2_act5", 32'(ch_active), 32'b0001);
        run_to(20);
        chk("t2_tick20", 32'(ch_tick), 32'b0001);
        chk("t2_wave20", 32'(ch_wave), 32'b0001);
        run_to(35);
        chk("t2_tick35", 32'(ch_tick), 32'b0001);
        chk("t2_wave35", 32'(ch_wave), 32'b0000);

        // 3: ch3 period 1 requested on a base-tick cycle, ch0 keeps running
        run_to(39);
        step(1'b1, 2'd3, 16'd1);
        run_to(45);
        chk("t3_done45", 32'(cfg_done), 32'd1);
        run_to(50);
        chk("t3_tick50", 32'(ch_tick), 32'b1001);

        // 4: disable the running ch0, ch3 continues
        step(1'b1, 2'd0, 16'd0);
        run_to(90);
        chk("t4_act", 32'(ch_active), 32'b1000);
        chk("t4_wave0", 32'(ch_wave[0]), 32'd0);

        // 5: reset while an update is pending
        do_reset(1);
        run_to(1);
        step(1'b1, 2'd1, 16'd2);
        run_to(3);
        do_reset(1);
        run_to(4);
        chk("t5_base4", 32'(base_tick), 32'd1);
        run_to(12);
        chk("t5_act", 32'(ch_active), 32'd0);

        // 6: cfg_valid held across two back-to-back requests
        do_reset(2);
        while (rel < 11)
            step(1'b1, (rel < 6) ? 2'd0 : 2'd2, (rel < 6) ? 16'd2 : 16'd4);
        run_to(40);

        // randomized traffic, with one reset in the middle
        do_reset(2);
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset(2);
            step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
